parking_ctrl: RTL and testbench
===============================

# parking_ctrl

Occupancy controller for the parking-slot system. Counts vehicles from entry/exit sensors, drives the barrier gate, and sequences a 4-digit multiplexed message ("OPEN" or "FULL") into the shared seven-segment decoder, one digit code per scan slot. It is the only block that writes the decoder's 4-bit `display` code.

## Interface

**Parameters**
- `SLOTS`, 8: capacity. Legal range 1..15.
- `CNT_W`, 4: width of the occupancy count.
- `GATE_CYC`, 6: cycles the gate stays open per admitted vehicle. Must be ≥1.
- `SCAN_DIV`, 4: clock cycles each digit is displayed. Must be ≥1.

**Ports**
- `clk` in 1: single clock.
- `rst` in 1: reset is asynchronous and active-high.
- `entry_in` in 1: entry sensor level, synchronous to `clk`.
- `exit_in` in 1: exit sensor level, synchronous to `clk`.
- `occ_count` out CNT_W: current occupancy.
- `full` out 1: high when `occ_count == SLOTS`.
- `gate_open` out 1: barrier drive.
- `display` out 4: decoder code. 0=L, 1=U, 2=F, 3=O, 4=P, 5=E, 6=N.
- `digit_en` out 4: one-hot digit select. Bit 0 is the leftmost digit.
- `err` out 1: error flag (see Configuration).

## Operation

**Edge detect**
- `entry_q` and `exit_q` are one-cycle registered copies of the sensor inputs.
- An event is `in & ~q`, evaluated combinationally in the cycle the input is first high.

**Occupancy**, updated at the clock edge that ends the event cycle:
- Entry only, not full: `occ_count + 1`. Gate is admitted.
- Entry only, full: count unchanged, gate stays as is. Rejected.
- Exit only, count > 0: `occ_count − 1`.
- Exit only, count == 0: count unchanged. Underflow.
- Entry and exit in the same cycle: count unchanged, gate admitted. This holds even when full, since the exit frees the slot.
- `full` is registered and recomputed from the next count at the same edge.

**Gate FSM**
- States: CLOSED and OPEN, with a timer `gtmr`.
- CLOSED → OPEN on admit, loading `gtmr = GATE_CYC − 1`.
- In OPEN: `gtmr` decrements each cycle. At 0, go to CLOSED.
- An admit while in OPEN reloads `gtmr = GATE_CYC − 1` and the FSM stays in OPEN.
- `gate_open` = (state == OPEN).

**Display sequencer**
- `scnt` counts 0..SCAN_DIV−1.
- When `scnt` wraps, `dig` (0..3) advances, wrapping 3→0.
- The message is latched from `full` only when `dig` wraps 3→0, so no mixed words appear.
- FULL message: codes 2, 1, 0, 0. OPEN message: codes 3, 4, 5, 6.
- `display` = message[dig]. `digit_en` = 1 << dig.

## Timing

**Reset values**
- `occ_count` = 0, `full` = 0, `gate_open` = 0 (CLOSED).
- `scnt` = 0, `dig` = 0, `digit_en` = 4'b0001.
- Latched message = OPEN, so `display` = 3.
- `err` = 0, `entry_q` = `exit_q` = 0.

**Latency**
- Sensor high at edge N: `occ_count`, `full` and `gate_open` change at edge N+1.
- `gate_open` stays high for exactly GATE_CYC cycles after the last admit.

**Holding sensors**
- A sensor held high is one event.
- A re-trigger requires at least one low sample.

**Display timing**
- Each digit is shown for SCAN_DIV cycles. A full frame is 4·SCAN_DIV cycles.
- A `full` change is shown starting at the next frame boundary. Worst case is 4·SCAN_DIV cycles later.

**Reset mid-operation**
- Gate closes and count clears immediately (asynchronously).
- A sensor still high at deassertion counts as an event on the first clocked cycle, because `q` = 0 after reset.

## Configuration

`PARK_ERR_EN`:
- **Defined:** `err` is set at the edge after a rejected entry or an underflow exit.
  - `err` is sticky until `rst`.
  - While `err` = 1, the latched message at each frame start becomes E, L, L, 0 → codes 5, 0, 0, 3 ("ELLO" pattern, used as the error banner). Counting and gate behaviour are unchanged.
- **Not defined:** `err` is tied to 0. The error logic and error message are not compiled.

## Test plan

- **Fill and overflow.** Reset, SLOTS=8, 9 separate entry pulses (1 high, 2 low).
  - `occ_count` reaches 8, `full` = 1, the 9th pulse leaves `occ_count` = 8 with no gate.
  - With `PARK_ERR_EN`: `err` = 1.
- **Underflow.** Reset, one exit pulse.
  - `occ_count` stays 0, `gate_open` stays 0.
  - With macro: `err` = 1 and the next frame shows 5, 0, 0, 3.
- **Simultaneous events.** At count 8, entry and exit pulses in the same cycle.
  - Count stays 8, `gate_open` = 1 for 6 cycles.
- **Gate reload.** Two admits 3 cycles apart, GATE_CYC=6.
  - `gate_open` is high for 3 + 6 = 9 consecutive cycles.
- **Display scan.** SCAN_DIV=4, empty lot.
  - `digit_en` runs 0001, 0010, 0100, 1000 for 4 cycles each, with `display` 3, 4, 5, 6.
  - Reach full mid-frame: the current frame finishes as OPEN, then the next frame is 2, 1, 0, 0.
- **Async reset mid-gate.** Assert `rst` between clock edges while the gate is open and the count is 5.
  - `gate_open` = 0, `occ_count` = 0, `digit_en` = 0001 without waiting for a clock edge.

Source files
------------

// File: rtl/parking_ctrl_if.sv
// Sensor/display bundle for parking_ctrl.
// The controller takes the slave side: it reads the sensors and drives
// occupancy, gate, display and error outputs.
interface parking_ctrl_if #(
  parameter int CNT_W = 4
);
  logic             entry_in;
  logic             exit_in;
  logic [CNT_W-1:0] occ_count;
  logic             full;
  logic             gate_open;
  logic [3:0]       display;
  logic [3:0]       digit_en;
  logic             err;

  modport master (
    output entry_in, exit_in,
    input  occ_count, full, gate_open, display, digit_en, err
  );

  modport slave (
    input  entry_in, exit_in,
    output occ_count, full, gate_open, display, digit_en, err
  );
endinterface

// File: rtl/parking_ctrl.sv
// Parking occupancy controller: sensor edge detect, occupancy count,
// barrier gate timer FSM and a 4-digit "OPEN"/"FULL" scan sequencer.
// Optional feature macro: PARK_ERR_EN (sticky err flag on rejected entry
// or underflow exit, plus the 5,0,0,3 error banner). Undefined: err = 0.
module parking_ctrl #(
  parameter int SLOTS    = 8,
  parameter int CNT_W    = 4,
  parameter int GATE_CYC = 6,
  parameter int SCAN_DIV = 4
) (
  input  logic            clk,
  input  logic            rst,
  parking_ctrl_if.slave   bus
);
  localparam int TW = (GATE_CYC > 1) ? $clog2(GATE_CYC) : 1;
  localparam int SW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(SLOTS);
  localparam logic [TW-1:0]    GT_LOAD  = TW'(GATE_CYC - 1);
  localparam logic [SW-1:0]    SC_MAX   = SW'(SCAN_DIV - 1);

  typedef enum logic {G_CLOSED, G_OPEN} gate_t;
  typedef enum logic [1:0] {M_OPEN, M_FULL, M_ERR} msg_t;

  logic             entry_q, exit_q;
  logic             ent_ev, ext_ev;
  logic [CNT_W-1:0] occ_count, occ_nxt;
  logic             full;
  logic             admit;
  gate_t            gst, gst_nxt;
  logic [TW-1:0]    gtmr, gtmr_nxt;
  logic             gate_open;
  logic [SW-1:0]    scnt;
  logic [1:0]       dig;
  msg_t             msg, msg_nxt;
  logic [3:0]       display;
  logic             err;

  // One-cycle sensor history for rising-edge detection.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      entry_q <= 1'b0;
      exit_q  <= 1'b0;
    end else begin
      entry_q <= bus.entry_in;
      exit_q  <= bus.exit_in;
    end
  end

  assign ent_ev = bus.entry_in & ~entry_q;
  assign ext_ev = bus.exit_in  & ~exit_q;

  // Event decode: next occupancy and whether the gate admits a vehicle.
  // A simultaneous entry+exit always admits, since the exit frees a slot.
  always_comb begin
    occ_nxt = occ_count;
    admit   = 1'b0;
    if (ent_ev && ext_ev) begin
      admit = 1'b1;
    end else if (ent_ev) begin
      if (occ_count != FULL_CNT) begin
        admit   = 1'b1;
        occ_nxt = occ_count + CNT_W'(1);
      end
    end else if (ext_ev) begin
      if (occ_count != '0) occ_nxt = occ_count - CNT_W'(1);
    end
  end

  // Occupancy and registered full flag, both from the next count.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      occ_count <= '0;
      full      <= 1'b0;
    end else begin
      occ_count <= occ_nxt;
      full      <= (occ_nxt == FULL_CNT);
    end
  end

  // Gate FSM state and timer register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      gst  <= G_CLOSED;
      gtmr <= '0;
    end else begin
      gst  <= gst_nxt;
      gtmr <= gtmr_nxt;
    end
  end

  // Gate FSM next state: an admit (re)loads the timer; OPEN closes at 0.
  always_comb begin
    gst_nxt  = gst;
    gtmr_nxt = gtmr;
    if (admit) begin
      gst_nxt  = G_OPEN;
      gtmr_nxt = GT_LOAD;
    end else if (gst == G_OPEN) begin
      if (gtmr == '0) gst_nxt  = G_CLOSED;
      else            gtmr_nxt = gtmr - TW'(1);
    end
  end

  // Gate FSM output.
  always_comb begin
    gate_open = (gst == G_OPEN);
  end

`ifdef PARK_ERR_EN
  logic err_ev;
  assign err_ev = (ent_ev & ~ext_ev & (occ_count == FULL_CNT)) |
                  (ext_ev & ~ent_ev & (occ_count == '0));

  // Sticky error flag, cleared only by reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) err <= 1'b0;
    else     err <= err | err_ev;
  end

  assign msg_nxt = err ? M_ERR : (full ? M_FULL : M_OPEN);
`else
  assign err     = 1'b0;
  assign msg_nxt = full ? M_FULL : M_OPEN;
`endif

  // Scan sequencer; the message only changes at a frame boundary so a
  // frame never mixes two words.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      scnt <= '0;
      dig  <= 2'd0;
      msg  <= M_OPEN;
    end else if (scnt == SC_MAX) begin
      scnt <= '0;
      dig  <= dig + 2'd1;
      if (dig == 2'd3) msg <= msg_nxt;
    end else begin
      scnt <= scnt + SW'(1);
    end
  end

  // Decoder code for the current digit of the latched message.
  always_comb begin
    display = 4'd3 + {2'b00, dig};
    case (msg)
      M_FULL: begin
        case (dig)
          2'd0:    display = 4'd2;
          2'd1:    display = 4'd1;
          default: display = 4'd0;
        endcase
      end
`ifdef PARK_ERR_EN
      M_ERR: begin
        case (dig)
          2'd0:    display = 4'd5;
          2'd3:    display = 4'd3;
          default: display = 4'd0;
        endcase
      end
`endif
      default: display = 4'd3 + {2'b00, dig};
    endcase
  end

  assign bus.occ_count = occ_count;
  assign bus.full      = full;
  assign bus.gate_open = gate_open;
  assign bus.display   = display;
  assign bus.digit_en  = 4'b0001 << dig;
  assign bus.err       = err;
endmodule

// File: tb/tb_parking_ctrl.sv
// Directed bench for parking_ctrl: vector table for fill/overflow, hand
// sequences for simultaneous events, gate reload, underflow, scan and reset.
module tb_parking_ctrl;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   ncmp = 0;
  int   nerr = 0;

`ifdef PARK_ERR_EN
  localparam bit ERR_EN = 1'b1;
`else
  localparam bit ERR_EN = 1'b0;
`endif

  parking_ctrl_if #(.CNT_W(4)) bus ();

  parking_ctrl #(.SLOTS(8), .CNT_W(4), .GATE_CYC(6), .SCAN_DIV(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic ent;
    logic ext;
    int   cnt;
    logic full;
    logic gate;
    logic err;
  } vec_t;

  vec_t vecs [30];

  task automatic chk(input string name, input int act, input int exp);
    ncmp++;
    if (act != exp) begin
      nerr++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    bus.entry_in = 1'b0;
    bus.exit_in  = 1'b0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  task automatic wait_en(input logic [3:0] v);
    int n = 0;
    while (bus.digit_en != v && n < 40) begin
      tick();
      n++;
    end
    if (bus.digit_en != v) chk("wait_digit_en_timeout", 0, 1);
  endtask

  task automatic pulse_entry();
    bus.entry_in = 1'b1;
    tick();
    bus.entry_in = 1'b0;
    tick();
  endtask

  initial begin
    int run;
    int n;
    int idx;
    logic [3:0] full_codes [4];
    logic [3:0] err_codes  [4];
    full_codes = '{4'd2, 4'd1, 4'd0, 4'd0};
    err_codes  = '{4'd5, 4'd0, 4'd0, 4'd3};

    // Fill/overflow table: entry pulse every 3 cycles, 9 pulses.
    for (int k = 0; k < 30; k++) begin
      vecs[k].ent  = (k % 3 == 0) && (k / 3 < 9);
      vecs[k].ext  = 1'b0;
      vecs[k].cnt  = (k / 3 + 1 > 8) ? 8 : k / 3 + 1;
      vecs[k].full = (k >= 21);
      vecs[k].gate = (k <= 26);
      vecs[k].err  = ERR_EN && (k >= 24);
    end

    // Reset values
    bus.entry_in = 1'b0;
    bus.exit_in  = 1'b0;
    #2;
    chk("rst_occ", bus.occ_count, 0);
    chk("rst_full", bus.full, 0);
    chk("rst_gate", bus.gate_open, 0);
    chk("rst_display", bus.display, 3);
    chk("rst_digit_en", bus.digit_en, 1);
    chk("rst_err", bus.err, 0);

    do_reset();
    for (int k = 0; k < 30; k++) begin
      bus.entry_in = vecs[k].ent;
      bus.exit_in  = vecs[k].ext;
      tick();
      chk($sformatf("fill_occ[%0d]", k), bus.occ_count, vecs[k].cnt);
      chk($sformatf("fill_full[%0d]", k), bus.full, vecs[k].full);
      chk($sformatf("fill_gate[%0d]", k), bus.gate_open, vecs[k].gate);
      chk($sformatf("fill_err[%0d]", k), bus.err, vecs[k].err);
    end

    // Simultaneous entry+exit at full: count holds, gate opens 6 cycles.
    bus.entry_in = 1'b1;
    bus.exit_in  = 1'b1;
    tick();
    bus.entry_in = 1'b0;
    bus.exit_in  = 1'b0;
    chk("sim_occ", bus.occ_count, 8);
    chk("sim_full", bus.full, 1);
    run = bus.gate_open ? 1 : 0;
    n = 0;
    while (bus.gate_open && n < 20) begin
      tick();
      if (bus.gate_open) run++;
      n++;
    end
    chk("sim_gate_cycles", run, 6);

    // Gate reload: admits 3 cycles apart give 9 open cycles.
    do_reset();
    bus.entry_in = 1'b1;
    tick();
    run = bus.gate_open ? 1 : 0;
    bus.entry_in = 1'b0;
    tick(); if (bus.gate_open) run++;
    tick(); if (bus.gate_open) run++;
    bus.entry_in = 1'b1;
    tick(); if (bus.gate_open) run++;
    bus.entry_in = 1'b0;
    n = 0;
    while (bus.gate_open && n < 20) begin
      tick();
      if (bus.gate_open) run++;
      n++;
    end
    chk("reload_gate_cycles", run, 9);
    chk("reload_occ", bus.occ_count, 2);

    // Underflow: exit on empty lot.
    do_reset();
    bus.exit_in = 1'b1;
    tick();
    bus.exit_in = 1'b0;
    chk("uf_occ", bus.occ_count, 0);
    chk("uf_gate", bus.gate_open, 0);
    chk("uf_err", bus.err, ERR_EN);
    tick();
    chk("uf_gate2", bus.gate_open, 0);
    if (ERR_EN) begin
      wait_en(4'b1000);
      wait_en(4'b0001);
      for (int s = 0; s < 16; s++) begin
        chk($sformatf("uf_banner[%0d]", s), bus.display, err_codes[s / 4]);
        tick();
      end
    end

    // Display scan on an empty lot.
    do_reset();
    for (int s = 0; s < 16; s++) begin
      chk($sformatf("scan_en[%0d]", s), bus.digit_en, 4'b0001 << (s / 4));
      chk($sformatf("scan_disp[%0d]", s), bus.display, 3 + s / 4);
      tick();
    end

    // Reach full mid-frame: rest of frame stays OPEN, next frame is FULL.
    do_reset();
    for (int i = 0; i < 7; i++) pulse_entry();
    wait_en(4'b0010);
    bus.entry_in = 1'b1;
    tick();
    bus.entry_in = 1'b0;
    chk("mid_full", bus.full, 1);
    n = 0;
    while (bus.digit_en != 4'b0001 && n < 16) begin
      idx = (bus.digit_en == 4'b0010) ? 1 : (bus.digit_en == 4'b0100) ? 2 : 3;
      chk("mid_open_disp", bus.display, 3 + idx);
      tick();
      n++;
    end
    if (bus.digit_en != 4'b0001) chk("mid_frame_timeout", 0, 1);
    for (int s = 0; s < 16; s++) begin
      chk($sformatf("full_en[%0d]", s), bus.digit_en, 4'b0001 << (s / 4));
      chk($sformatf("full_disp[%0d]", s), bus.display, full_codes[s / 4]);
      tick();
    end

    // Async reset mid-gate at count 5.
    do_reset();
    for (int i = 0; i < 4; i++) pulse_entry();
    bus.entry_in = 1'b1;
    tick();
    bus.entry_in = 1'b0;
    chk("ar_pre_occ", bus.occ_count, 5);
    chk("ar_pre_gate", bus.gate_open, 1);
    #2;
    rst = 1'b1;
    #1;
    chk("ar_gate", bus.gate_open, 0);
    chk("ar_occ", bus.occ_count, 0);
    chk("ar_digit_en", bus.digit_en, 1);
    chk("ar_full", bus.full, 0);

    // Sensor held high through reset release counts once.
    bus.entry_in = 1'b1;
    tick();
    rst = 1'b0;
    tick();
    chk("held_occ", bus.occ_count, 1);
    chk("held_gate", bus.gate_open, 1);
    tick();
    tick();
    chk("held_once_occ", bus.occ_count, 1);
    bus.entry_in = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
    $finish;
  end
endmodule
